monitor_comparativo: RTL and testbench

//  Synthesizable, parametrised comparison monitor for N implementations of one block
//  (conductual, estructural, yosys, ...).

---
 rtl/monitor_comparativo_pkg.sv | 21 ++
 rtl/monitor_comparativo_if.sv | 31 +++
 rtl/monitor_comparativo_contador_sat.sv | 30 +++
 rtl/monitor_comparativo.sv | 99 +++++++++
 tb/tb_monitor_comparativo.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/monitor_comparativo_pkg.sv
// Shared defaults and helpers for the comparison monitor.
package monitor_comparativo_pkg;

   localparam int DEF_WIDTH   = 2;
   localparam int DEF_NUM_DUT = 3;
   localparam int DEF_CNT_W   = 4;
   localparam int DEF_TS_W    = 8;

   // Counter overflow behaviour selectors
   localparam int SAT_WRAP  = 0;
   localparam int SAT_CLAMP = 1;

   // Number of set bits in a word; callers zero-extend narrower slices
   function automatic int unsigned popcount(input logic [31:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 32; i++) n = n + {31'b0, v[i]};
      return n;
   endfunction

endpackage

// File: rtl/monitor_comparativo_if.sv
// Data/result bundle between the comparative bench and the monitor.
interface monitor_comparativo_if #(
   parameter int WIDTH   = 2,
   parameter int NUM_DUT = 3,
   parameter int CNT_W   = 4,
   parameter int TS_W    = 8
);
   logic                       enable;
   logic                       clear;
   logic [NUM_DUT*WIDTH-1:0]   data_in;
   logic                       check;
   logic [NUM_DUT-2:0]         mismatch_vec;
   logic                       err_sticky;
   logic [CNT_W-1:0]           err_count;
   logic [TS_W-1:0]            sample_count;
   logic [TS_W-1:0]            first_err_ts;
   logic                       first_err_vld;
   logic [NUM_DUT*CNT_W-1:0]   rise_count;

   modport master (
      output enable, clear, data_in,
      input  check, mismatch_vec, err_sticky, err_count, sample_count,
             first_err_ts, first_err_vld, rise_count
   );

   modport slave (
      input  enable, clear, data_in,
      output check, mismatch_vec, err_sticky, err_count, sample_count,
             first_err_ts, first_err_vld, rise_count
   );
endinterface

// File: rtl/monitor_comparativo_contador_sat.sv
// Event counter with variable increment, optional saturation, and clear.
module contador_sat #(
   parameter int CNT_W = 4,
   parameter int INC_W = 2,
   parameter int SAT   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             en,
   input  logic [INC_W-1:0] inc,
   output logic [CNT_W-1:0] q
);
   logic [CNT_W-1:0] r_q;
   logic [CNT_W:0]   w_sum;

   // One spare bit on top of the counter exposes overflow directly
   assign w_sum = {1'b0, r_q} + {{(CNT_W+1-INC_W){1'b0}}, inc};
   assign q     = r_q;

   // Clear beats counting; overflow either clamps or drops the carry
   always_ff @(posedge clk) begin
      if (reset)                       r_q <= '0;
      else if (clear)                  r_q <= '0;
      else if (en) begin
         if (SAT != 0 && w_sum[CNT_W]) r_q <= '1;
         else                          r_q <= w_sum[CNT_W-1:0];
      end
   end
endmodule

// File: rtl/monitor_comparativo.sv
// Compares N implementation outputs against slice 0 each sampled cycle,
// counting mismatching samples, per-slice rising bits and first-error time.
module monitor_comparativo
   import monitor_comparativo_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NUM_DUT = DEF_NUM_DUT,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int TS_W    = DEF_TS_W,
   parameter int SAT     = SAT_CLAMP
) (
   input  logic                clk,
   input  logic                reset,
   monitor_comparativo_if.slave bus
);
   localparam int INC_W = $clog2(WIDTH + 1);

   logic [NUM_DUT-1:0][WIDTH-1:0] w_slice;
   logic [NUM_DUT-1:0][WIDTH-1:0] r_prev;
   logic [NUM_DUT-1:0][CNT_W-1:0] w_rise;
   logic [NUM_DUT-2:0]            w_mm;
   logic [NUM_DUT-2:0]            r_mm;
   logic                          w_any;
   logic                          r_check;
   logic                          r_sticky;
   logic                          r_first_vld;
   logic [TS_W-1:0]               r_sample;
   logic [TS_W-1:0]               r_first_ts;
   logic [CNT_W-1:0]              w_err_cnt;

   assign w_slice = bus.data_in;

   genvar g;
   generate
      for (g = 1; g < NUM_DUT; g++) begin : g_cmp
         assign w_mm[g-1] = (w_slice[g] != w_slice[0]);
      end

      for (g = 0; g < NUM_DUT; g++) begin : g_rise
         logic [INC_W-1:0] w_inc;
         assign w_inc = INC_W'(popcount(32'(~r_prev[g] & w_slice[g])));
         contador_sat #(.CNT_W(CNT_W), .INC_W(INC_W), .SAT(SAT)) u_rise (
            .clk(clk), .reset(reset), .clear(bus.clear), .en(bus.enable),
            .inc(w_inc), .q(w_rise[g])
         );
      end
   endgenerate

   assign w_any = |w_mm;

   contador_sat #(.CNT_W(CNT_W), .INC_W(1), .SAT(SAT)) u_err (
      .clk(clk), .reset(reset), .clear(bus.clear), .en(bus.enable),
      .inc(w_any), .q(w_err_cnt)
   );

   // Compare flags, sample clock, first-error capture and previous-sample store.
   // prev follows the data even on a clearing sample so no false rises appear.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev      <= '0;
         r_check     <= 1'b1;
         r_mm        <= '0;
         r_sticky    <= 1'b0;
         r_sample    <= '0;
         r_first_ts  <= '0;
         r_first_vld <= 1'b0;
      end else begin
         if (bus.enable) r_prev <= w_slice;
         if (bus.clear) begin
            r_check     <= 1'b1;
            r_mm        <= '0;
            r_sticky    <= 1'b0;
            r_sample    <= '0;
            r_first_ts  <= '0;
            r_first_vld <= 1'b0;
         end else if (bus.enable) begin
            r_check  <= ~w_any;
            r_mm     <= w_mm;
            r_sample <= r_sample + 1'b1;
            if (w_any) begin
               r_sticky <= 1'b1;
               if (!r_first_vld) begin
                  r_first_ts  <= r_sample;
                  r_first_vld <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.check         = r_check;
   assign bus.mismatch_vec  = r_mm;
   assign bus.err_sticky    = r_sticky;
   assign bus.err_count     = w_err_cnt;
   assign bus.sample_count  = r_sample;
   assign bus.first_err_ts  = r_first_ts;
   assign bus.first_err_vld = r_first_vld;
   assign bus.rise_count    = w_rise;
endmodule

// File: tb/tb_monitor_comparativo.sv
// Bench: directed table, corner sequences and random traffic against a
// behavioural model, run on a saturating and a wrapping instance together.
module tb_monitor_comparativo;
   logic clk = 1'b0;
   logic reset;
   int   n_asr = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   monitor_comparativo_if #(.WIDTH(2), .NUM_DUT(3), .CNT_W(4), .TS_W(8)) if_s ();
   monitor_comparativo_if #(.WIDTH(2), .NUM_DUT(3), .CNT_W(4), .TS_W(8)) if_w ();

   monitor_comparativo #(.WIDTH(2), .NUM_DUT(3), .CNT_W(4), .TS_W(8), .SAT(1)) u_sat (
      .clk(clk), .reset(reset), .bus(if_s.slave));
   monitor_comparativo #(.WIDTH(2), .NUM_DUT(3), .CNT_W(4), .TS_W(8), .SAT(0)) u_wrap (
      .clk(clk), .reset(reset), .bus(if_w.slave));

   // ---------------- reference model (unbounded totals, reduced on compare)
   int m_samp, m_err_tot, m_fts, m_mm;
   int m_rise_tot[3];
   int m_prev[3];
   bit m_chk, m_stk, m_fvl;

   function automatic int cap(input int tot, input int sat);
      if (sat != 0) return (tot > 15) ? 15 : tot;
      return tot % 16;
   endfunction

   task automatic m_step(input bit r, input bit e, input bit c, input logic [5:0] d);
      int s[3];
      int anym;
      for (int k = 0; k < 3; k++) s[k] = int'((d >> (2*k)) & 6'd3);
      if (r) begin
         m_samp = 0; m_err_tot = 0; m_fts = 0; m_mm = 0;
         m_chk = 1; m_stk = 0; m_fvl = 0;
         for (int k = 0; k < 3; k++) begin m_rise_tot[k] = 0; m_prev[k] = 0; end
      end else if (c) begin
         m_samp = 0; m_err_tot = 0; m_fts = 0; m_mm = 0;
         m_chk = 1; m_stk = 0; m_fvl = 0;
         for (int k = 0; k < 3; k++) begin
            m_rise_tot[k] = 0;
            if (e) m_prev[k] = s[k];
         end
      end else if (e) begin
         m_mm = 0;
         for (int k = 1; k < 3; k++) if (s[k] != s[0]) m_mm |= (1 << (k-1));
         anym = (m_mm != 0) ? 1 : 0;
         m_chk = (anym == 0);
         if (anym != 0) begin
            m_stk = 1;
            m_err_tot++;
            if (!m_fvl) begin m_fts = m_samp; m_fvl = 1; end
         end
         for (int k = 0; k < 3; k++) begin
            m_rise_tot[k] += $countones(~m_prev[k] & s[k] & 3);
            m_prev[k] = s[k];
         end
         m_samp = (m_samp + 1) % 256;
      end
   endtask

   // ---------------- checking helpers
   task automatic chk(input string name, input int act, input int exp);
      n_asr++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cmp_model();
      chk("s.check",  int'(if_s.check), int'(m_chk));
      chk("s.mm",     int'(if_s.mismatch_vec), m_mm);
      chk("s.sticky", int'(if_s.err_sticky), int'(m_stk));
      chk("s.errc",   int'(if_s.err_count), cap(m_err_tot, 1));
      chk("s.samp",   int'(if_s.sample_count), m_samp);
      chk("s.fts",    int'(if_s.first_err_ts), m_fts);
      chk("s.fvld",   int'(if_s.first_err_vld), int'(m_fvl));
      chk("w.errc",   int'(if_w.err_count), cap(m_err_tot, 0));
      chk("w.check",  int'(if_w.check), int'(m_chk));
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("s.rise%0d", k), int'(if_s.rise_count[k*4 +: 4]), cap(m_rise_tot[k], 1));
         chk($sformatf("w.rise%0d", k), int'(if_w.rise_count[k*4 +: 4]), cap(m_rise_tot[k], 0));
      end
   endtask

   // Drive one cycle, advance the model on the edge, sample 1 time unit later
   task automatic step(input bit r, input bit e, input bit c, input logic [5:0] d);
      reset = r;
      if_s.enable = e; if_s.clear = c; if_s.data_in = d;
      if_w.enable = e; if_w.clear = c; if_w.data_in = d;
      @(posedge clk);
      m_step(r, e, c, d);
      #1;
   endtask

   // ---------------- directed table
   typedef struct {
      bit rst, en, clr; logic [5:0] d;
      int e_chk, e_mm, e_stk, e_err, e_smp, e_fts, e_fvl, e_r0, e_r1, e_r2;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t mk(input bit r, e, c, input logic [5:0] d,
                               input int ck, mm, st, er, sm, ft, fv, r0, r1, r2);
      vec_t v;
      v.rst = r; v.en = e; v.clr = c; v.d = d;
      v.e_chk = ck; v.e_mm = mm; v.e_stk = st; v.e_err = er; v.e_smp = sm;
      v.e_fts = ft; v.e_fvl = fv; v.e_r0 = r0; v.e_r1 = r1; v.e_r2 = r2;
      return v;
   endfunction

   initial begin
      reset = 1'b1;
      if_s.enable = 0; if_s.clear = 0; if_s.data_in = '0;
      if_w.enable = 0; if_w.clear = 0; if_w.data_in = '0;

      //             r e c data   chk mm stk err smp fts fvl r0 r1 r2
      tbl.push_back(mk(1,0,0,6'h3F, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1,0,0,6'h3F, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0,1,0,6'h15, 1, 0, 0, 0, 1, 0, 0, 1, 1, 1));
      tbl.push_back(mk(0,1,0,6'h15, 1, 0, 0, 0, 2, 0, 0, 1, 1, 1));
      tbl.push_back(mk(0,1,0,6'h15, 1, 0, 0, 0, 3, 0, 0, 1, 1, 1));
      tbl.push_back(mk(1,0,0,6'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0,1,0,6'h00, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0,1,0,6'h04, 0, 1, 1, 1, 2, 1, 1, 0, 1, 0));
      tbl.push_back(mk(0,1,0,6'h3F, 1, 0, 1, 1, 3, 1, 1, 2, 2, 2));
      tbl.push_back(mk(0,1,1,6'h3F, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0,1,0,6'h3F, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0,1,1,6'h04, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0,1,0,6'h04, 0, 1, 1, 1, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0,0,0,6'h3A, 0, 1, 1, 1, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0,0,1,6'h3F, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0,1,0,6'h3F, 1, 0, 0, 0, 1, 0, 0, 2, 1, 2));
      tbl.push_back(mk(0,1,0,6'h2F, 0, 2, 1, 1, 2, 1, 1, 2, 1, 2));
      tbl.push_back(mk(0,1,0,6'h00, 1, 0, 1, 1, 3, 1, 1, 2, 1, 2));

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].en, tbl[i].clr, tbl[i].d);
         chk($sformatf("t%0d.check", i),  int'(if_s.check),         tbl[i].e_chk);
         chk($sformatf("t%0d.mm", i),     int'(if_s.mismatch_vec),  tbl[i].e_mm);
         chk($sformatf("t%0d.sticky", i), int'(if_s.err_sticky),    tbl[i].e_stk);
         chk($sformatf("t%0d.errc", i),   int'(if_s.err_count),     tbl[i].e_err);
         chk($sformatf("t%0d.samp", i),   int'(if_s.sample_count),  tbl[i].e_smp);
         chk($sformatf("t%0d.fts", i),    int'(if_s.first_err_ts),  tbl[i].e_fts);
         chk($sformatf("t%0d.fvld", i),   int'(if_s.first_err_vld), tbl[i].e_fvl);
         chk($sformatf("t%0d.rise0", i),  int'(if_s.rise_count[3:0]),  tbl[i].e_r0);
         chk($sformatf("t%0d.rise1", i),  int'(if_s.rise_count[7:4]),  tbl[i].e_r1);
         chk($sformatf("t%0d.rise2", i),  int'(if_s.rise_count[11:8]), tbl[i].e_r2);
      end

      // Slice 0 toggles 00/11: rise totals 2,2,4,4,... up to 20
      step(1, 0, 0, 6'h00);
      for (int i = 0; i < 20; i++) begin
         step(0, 1, 0, (i % 2 == 0) ? 6'h03 : 6'h00);
         cmp_model();
      end
      chk("sat.clamp", int'(if_s.rise_count[3:0]), 15);
      chk("wrap.mod",  int'(if_w.rise_count[3:0]), 4);

      // Reset while err_count=5, then one rising sample on slice 0
      step(1, 0, 0, 6'h00);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 6'h04);
      chk("mid.errc5", int'(if_s.err_count), 5);
      step(1, 1, 1, 6'h04);
      chk("mid.check",  int'(if_s.check), 1);
      chk("mid.errc0",  int'(if_s.err_count), 0);
      chk("mid.sticky", int'(if_s.err_sticky), 0);
      chk("mid.samp",   int'(if_s.sample_count), 0);
      chk("mid.fvld",   int'(if_s.first_err_vld), 0);
      cmp_model();
      step(0, 1, 0, 6'h03);
      chk("mid.rise0", int'(if_s.rise_count[3:0]), 2);
      cmp_model();

      // Random traffic
      step(1, 0, 0, 6'h00);
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(99) < 2, $urandom_range(99) < 75,
              $urandom_range(99) < 5, 6'($urandom));
         cmp_model();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asr, n_fail);
      $finish;
   end
endmodule
